mips32_mem_responder: RTL and testbench
=======================================

MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words in memory.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (0..15).
REQ-003 SHALL have port clk1  input  1  single clock; all logic on posedge. One clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator (MIPS32 core) presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store (SW), 0 = load (LW/fetch).
REQ-008 SHALL have port req_addr  input  32  word address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port rsp_rdata  output  32  load data; for stores, the written word.
REQ-013 SHALL have port rsp_err  output  1  address >= DEPTH.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid && req_ready at a posedge, latching we/addr/wdata; later input changes SHALL be ignored.
REQ-016 On acceptance, SHALL go to RESP if WAIT_CYCLES == 0, else to WAIT with counter loaded to WAIT_CYCLES-1.
REQ-017 In WAIT, SHALL decrement counter each cycle; at counter 0, SHALL commit access and go to RESP.
REQ-018 Commit: load SHALL capture Mem[addr] into rsp_rdata; store SHALL write Mem[addr] <= wdata and set rsp_rdata = wdata.
REQ-019 rsp_valid SHALL first assert WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready; then SHALL go to IDLE.
REQ-021 A new request SHALL NOT be accepted on the same edge as a response handshake; minimum back-to-back spacing is WAIT_CYCLES+2 cycles.
REQ-022 Outside RESP, rsp_valid SHALL be 0; rsp_rdata SHALL keep last value.

Reset
REQ-023 On rst_n == 0 at posedge: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready SHALL be 1 from the first post-reset cycle.
REQ-024 Reset during WAIT SHALL abandon the transaction; an uncommitted store SHALL NOT modify memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro MIPS32_MEM_ERR_CHECK_EN: when defined, addr >= DEPTH SHALL set rsp_err = 1 with rsp_rdata = 0 and a store SHALL be suppressed; when undefined, address SHALL be truncated to log2(DEPTH) bits and rsp_err SHALL be tied 0.

Structure
REQ-027 Package mips32_pkg SHALL hold opcode constants, instruction-type constants, MEM_DEPTH default, and the responder state typedef.
REQ-028 Storage SHALL be sub-module mips32_mem_array (single-port, synchronous write, registered read, DEPTH x 32).

Verification
REQ-029 Reset, then load addr 5 (preloaded 0xDEADBEEF), WAIT_CYCLES=2 -> rsp_valid exactly 3 cycles after acceptance, rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-030 Store 0x12345678 to addr 10, then load addr 10 -> second response rsp_rdata 0x12345678.
REQ-031 Hold rsp_ready low 4 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, second req_valid not accepted.
REQ-032 Assert rst_n low during WAIT of store 0xAAAA5555 to addr 7 -> rsp_valid 0, Mem[7] unchanged, req_ready 1 after reset.
REQ-033 With MIPS32_MEM_ERR_CHECK_EN, store to addr 1024 -> rsp_err 1, rsp_rdata 0, Mem[0] unchanged; without macro, same store writes Mem[0], rsp_err 0.
REQ-034 WAIT_CYCLES=0, load addr 0 -> rsp_valid on the cycle after acceptance.

Source files
------------

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 constants and memory responder types
package mips32_pkg;

    localparam int MEM_DEPTH = 1024;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] INSTR_TYPE_R = 2'd0;
    localparam logic [1:0] INSTR_TYPE_I = 2'd1;
    localparam logic [1:0] INSTR_TYPE_J = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

endpackage

// File: rtl/mips32_mem_array.sv
// rtl/mips32_mem_array.sv - single-port DEPTH x 32 RAM, sync write, registered write-first read
module mips32_mem_array
    import mips32_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk1) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            rdata <= 32'd0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - wait-state memory responder for a MIPS32 core; MIPS32_MEM_ERR_CHECK_EN enables range checking
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    rsp_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        commit;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        addr_err;
    logic        mem_en;
    logic [31:0] mem_rdata;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_ready && req_valid;

    // With zero wait states the access commits on the acceptance edge itself,
    // so the array is fed straight from the request inputs while idle.
    assign c_we    = (state_q == IDLE) ? req_we    : we_q;
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign commit = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0));

`ifdef MIPS32_MEM_ERR_CHECK_EN
    logic err_q;

    assign addr_err = (c_addr >= 32'(DEPTH));

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= addr_err;
        end
    end

    assign rsp_err   = err_q;
    assign rsp_rdata = err_q ? 32'd0 : mem_rdata;
`else
    logic unused_addr_hi;

    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^c_addr[31:AW];
    assign rsp_err        = 1'b0;
    assign rsp_rdata      = mem_rdata;
`endif

    // Gating with rst_n keeps a store from landing on the reset edge.
    assign mem_en = commit && rst_n && !addr_err;

    mips32_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk1  (clk1),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (c_we),
        .addr  (c_addr[AW-1:0]),
        .wdata (c_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb/tb_mips32_mem_responder.sv - directed table-driven bench for mips32_mem_responder
module tb_mips32_mem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int passed = 0;
    int total  = 0;

    always #5 clk1 = ~clk1;

    mips32_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk1(clk1), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mips32_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk1(clk1), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_txn(input int d, input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        int wc;
        wc = (d == 0) ? 2 : 0;
        @(negedge clk1);
        check({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk1);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(posedge clk1);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(wc + 1));
        check({tag, ".rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
        @(negedge clk1);
        rsp_ready[d] = 1'b1;
        @(posedge clk1);
        #1;
        rsp_ready[d] = 1'b0;
        check({tag, ".valid_after_hs"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, ".ready_after_hs"}, 32'(req_ready[d]), 32'd1);
    endtask

    vec_t vecs [11];
    int   lat;

    initial begin
        vecs[0]  = '{1'b1, 32'd5,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'd5,    32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd10,   32'h12345678, 32'h12345678, 1'b0};
        vecs[3]  = '{1'b0, 32'd10,   32'h0,        32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 32'd0,    32'h0BADF00D, 32'h0BADF00D, 1'b0};
        vecs[5]  = '{1'b1, 32'd1023, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 32'd1023, 32'h0,        32'hCAFEF00D, 1'b0};
`ifdef MIPS32_MEM_ERR_CHECK_EN
        vecs[7]  = '{1'b1, 32'd1024, 32'h11112222, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 32'd0,    32'h0,        32'h0BADF00D, 1'b0};
`else
        vecs[7]  = '{1'b1, 32'd1024, 32'h11112222, 32'h11112222, 1'b0};
        vecs[8]  = '{1'b0, 32'd0,    32'h0,        32'h11112222, 1'b0};
`endif
        vecs[9]  = '{1'b0, 32'd1023, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 32'd7,    32'h01234567, 32'h01234567, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d.req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("reset%0d.rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset%0d.rsp_rdata", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset%0d.rsp_err", d), 32'(rsp_err[d]), 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            do_txn(0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Response held for 4 cycles while a second request waits at the input.
        @(negedge clk1);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd5;
        @(posedge clk1);
        #1;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'h99999999;
        lat = 1;
        while (!rsp_valid[0] && lat < 20) begin
            @(posedge clk1);
            #1;
            lat++;
        end
        check("hold.latency", 32'(lat), 32'd3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk1);
            check($sformatf("hold%0d.rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("hold%0d.rsp_rdata", c), rsp_rdata[0], 32'hDEADBEEF);
            check($sformatf("hold%0d.req_ready", c), 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk1);
        rsp_ready[0] = 1'b1;
        @(posedge clk1);
        #1;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        check("hold.ready_after_hs", 32'(req_ready[0]), 32'd1);
        check("hold.valid_after_hs", 32'(rsp_valid[0]), 32'd0);
        do_txn(0, "hold_reread", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0);

        // Reset lands in WAIT of a store; the store must be abandoned.
        @(negedge clk1);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'd7;
        req_wdata[0] = 32'hAAAA5555;
        @(posedge clk1);
        #1;
        req_valid[0] = 1'b0;
        check("rstwait.req_ready_in_wait", 32'(req_ready[0]), 32'd0);
        @(negedge clk1);
        rst_n = 1'b0;
        @(posedge clk1);
        #1;
        check("rstwait.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstwait.rsp_rdata", rsp_rdata[0], 32'd0);
        check("rstwait.req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk1);
            check("rstwait.no_late_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        do_txn(0, "rstwait_reread", 1'b0, 32'd7, 32'h0, 32'h01234567, 1'b0);

        // Zero-wait-state instance.
        do_txn(1, "w0_store0", 1'b1, 32'd0, 32'h55AA55AA, 32'h55AA55AA, 1'b0);
        do_txn(1, "w0_load0", 1'b0, 32'd0, 32'h0, 32'h55AA55AA, 1'b0);
`ifdef MIPS32_MEM_ERR_CHECK_EN
        do_txn(1, "w0_load1024", 1'b0, 32'd1024, 32'h0, 32'h00000000, 1'b1);
`else
        do_txn(1, "w0_load1024", 1'b0, 32'd1024, 32'h0, 32'h55AA55AA, 1'b0);
`endif
        do_txn(1, "w0_load0_again", 1'b0, 32'd0, 32'h0, 32'h55AA55AA, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
